// File: rtl/multi_chan_queue_pkg.sv
// Sizing helpers and arbiter state encoding shared by the multi-channel queue.
package multi_chan_queue_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter; a grant found while idle is held until ack, or dropped when its requester is released.
// Combinational grant from the request vector or the held lock; pointer and lock update on the clock edge.
module rr_arb_lock
  import multi_chan_queue_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          ack,
  input  logic [N-1:0]  rel,
  output logic          vld,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  arb_state_e    state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] lock_q;
  logic          hi_vld, lo_vld;
  logic [IW-1:0] hi_idx, lo_idx;

  // Lowest requester at or above rr_q wins; otherwise wrap to the lowest below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (IW'(j) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = IW'(j);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IW'(j);
        end
      end
    end
  end

  always_comb begin
    if (state_q == ARB_LOCKED) begin
      vld = 1'b1;
      idx = lock_q;
    end else begin
      vld = hi_vld || lo_vld;
      idx = hi_vld ? hi_idx : lo_idx;
    end
    for (int j = 0; j < N; j++) begin
      gnt[j] = vld && (idx == IW'(j));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else if (vld && ack) begin
      state_q <= ARB_IDLE;
      rr_q    <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end else if (vld && !(|(rel & gnt))) begin
      state_q <= ARB_LOCKED;
      lock_q  <= idx;
    end else begin
      state_q <= ARB_IDLE;
    end
  end

endmodule

// File: rtl/multi_chan_queue.sv
// NUM_CH private FIFOs behind one steered enqueue port and one round-robin dequeue port; no flow-through.
// Optional per-channel occupancy counters on cnt_o when MULTI_CHAN_QUEUE_CNT_EN is defined.
module multi_chan_queue
  import multi_chan_queue_pkg::*;
#(
  parameter type T      = logic,
  parameter int  NUM_CH = 4,
  parameter int  DEPTH  = 4,
  parameter int  PIPE   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enq_valid_i,
  output logic                      enq_ready_o,
  input  logic [ch_w(NUM_CH)-1:0]   enq_ch_i,
  input  logic [$bits(T)-1:0]       enq_bits_i,
  output logic                      deq_valid_o,
  input  logic                      deq_ready_i,
  output logic [ch_w(NUM_CH)-1:0]   deq_ch_o,
  output logic [$bits(T)-1:0]       deq_bits_o,
  input  logic [NUM_CH-1:0]         flush_i
`ifdef MULTI_CHAN_QUEUE_CNT_EN
  ,
  output logic [NUM_CH*cnt_w(DEPTH)-1:0] cnt_o
`endif
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [NUM_CH-1:0] empty, full, do_enq, do_deq, gnt;
  logic              ch_ok, sel_full, sel_deq, deq_hs, arb_vld;
  logic [CH_W-1:0]   gnt_idx;
  T                  head [NUM_CH];

  assign ch_ok = {1'b0, enq_ch_i} < (CH_W + 1)'(NUM_CH);

  always_comb begin
    sel_full = 1'b0;
    sel_deq  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (enq_ch_i == CH_W'(c)) begin
        sel_full = full[c];
        sel_deq  = do_deq[c];
      end
    end
  end

  // With PIPE, a full channel still accepts when its head leaves in the same cycle.
  assign enq_ready_o = ch_ok && (!sel_full || ((PIPE != 0) && sel_deq));
  assign deq_hs      = arb_vld && deq_ready_i;
  assign do_deq      = gnt & {NUM_CH{deq_hs}};
  assign deq_valid_o = arb_vld;
  assign deq_ch_o    = gnt_idx;

  always_comb begin
    do_enq     = '0;
    deq_bits_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      do_enq[c] = enq_valid_i && enq_ready_o && (enq_ch_i == CH_W'(c));
      if (gnt_idx == CH_W'(c)) begin
        deq_bits_o = head[c];
      end
    end
  end

  rr_arb_lock #(
    .N  (NUM_CH),
    .IW (CH_W)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (~empty),
    .ack   (deq_hs),
    .rel   (flush_i),
    .vld   (arb_vld),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    T               mem_q [DEPTH];
    logic [PTR_W-1:0] enq_ptr_q, deq_ptr_q;
    logic           maybe_full_q;
    logic           ptr_match;

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty[c]  = ptr_match && !maybe_full_q;
    assign full[c]   = ptr_match && maybe_full_q;
    assign head[c]   = mem_q[deq_ptr_q];

    // Flush wins over any enqueue or dequeue on the same channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        enq_ptr_q    <= '0;
        deq_ptr_q    <= '0;
        maybe_full_q <= 1'b0;
      end else if (flush_i[c]) begin
        enq_ptr_q    <= '0;
        deq_ptr_q    <= '0;
        maybe_full_q <= 1'b0;
      end else begin
        if (do_enq[c]) enq_ptr_q <= enq_ptr_q + PTR_W'(1);
        if (do_deq[c]) deq_ptr_q <= deq_ptr_q + PTR_W'(1);
        if (do_enq[c] != do_deq[c]) maybe_full_q <= do_enq[c];
      end
    end

    always_ff @(posedge clk_i) begin
      if (do_enq[c] && !flush_i[c]) begin
        mem_q[enq_ptr_q] <= T'(enq_bits_i);
      end
    end

`ifdef MULTI_CHAN_QUEUE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (flush_i[c]) begin
        cnt_q <= '0;
      end else if (do_enq[c] && !do_deq[c]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_deq[c] && !do_enq[c]) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    assign cnt_o[c*CNT_W +: CNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_multi_chan_queue.sv
// Scoreboard bench for multi_chan_queue: per-channel order, round-robin grants, lock, flush, async reset.
module tb_multi_chan_queue;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [1:0]        enq_ch_i;
  logic [7:0]        enq_bits_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [1:0]        deq_ch_o;
  logic [7:0]        deq_bits_o;
  logic [NUM_CH-1:0] flush_i;
`ifdef MULTI_CHAN_QUEUE_CNT_EN
  logic [NUM_CH*CNT_W-1:0] cnt_o;
`endif

  multi_chan_queue #(
    .T      (logic [7:0]),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .PIPE   (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_ch_i    (enq_ch_i),
    .enq_bits_i  (enq_bits_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_ch_o    (deq_ch_o),
    .deq_bits_o  (deq_bits_o),
    .flush_i     (flush_i)
`ifdef MULTI_CHAN_QUEUE_CNT_EN
    ,
    .cnt_o       (cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] dat;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  logic       v, r;
  logic [1:0] oc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic [1:0] ch, input logic [7:0] bits);
    int   hit;
    hit = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (hit < 0 && sb_q[i].ch == ch) hit = i;
    end
    check("sb_has_entry", 32'(hit >= 0), 32'd1);
    if (hit >= 0) begin
      check("deq_bits", 32'(bits), 32'(sb_q[hit].dat));
      sb_q.delete(hit);
    end
  endtask

  task automatic sb_purge(input int ch);
    sb_t keep[$];
    foreach (sb_q[i]) if (int'(sb_q[i].ch) != ch) keep.push_back(sb_q[i]);
    sb_q = keep;
  endtask

  // One clock: drive at the falling edge, sample 1ns later, update the scoreboard.
  task automatic cyc(input logic ev, input logic [1:0] ch, input logic [7:0] d,
                     input logic rdy, input logic [3:0] fl,
                     output logic vld, output logic [1:0] och, output logic erdy);
    @(negedge clk_i);
    enq_valid_i = ev;
    enq_ch_i    = ch;
    enq_bits_i  = d;
    deq_ready_i = rdy;
    flush_i     = fl;
    #1;
    vld  = deq_valid_o;
    och  = deq_ch_o;
    erdy = enq_ready_o;
    if (vld && rdy) sb_pop(och, deq_bits_o);
    for (int c = 0; c < NUM_CH; c++) if (fl[c]) sb_purge(c);
    if (ev && erdy && !fl[ch]) sb_q.push_back({ch, d});
  endtask

  task automatic enq(input logic [1:0] ch, input logic [7:0] d);
    logic lv, lr;
    logic [1:0] lc;
    cyc(1'b1, ch, d, 1'b0, 4'b0, lv, lc, lr);
    check("enq_rdy", 32'(lr), 32'd1);
  endtask

  task automatic deq_one(input string tag, input logic [1:0] exp_ch);
    logic lv, lr;
    logic [1:0] lc;
    int n;
    n = 0;
    do begin
      cyc(1'b0, 2'd0, 8'h00, 1'b1, 4'b0, lv, lc, lr);
      n++;
    end while (!lv && n < 20);
    check({tag, "_vld"}, 32'(lv), 32'd1);
    check({tag, "_ch"}, 32'(lc), 32'(exp_ch));
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    enq_valid_i = 1'b0;
    enq_ch_i    = '0;
    enq_bits_i  = '0;
    deq_ready_i = 1'b0;
    flush_i     = '0;
    sb_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and in-order delivery on one channel
    do_reset();
    check("rst_enq_rdy", 32'(enq_ready_o), 32'd1);
    check("rst_deq_vld", 32'(deq_valid_o), 32'd0);
    check("rst_deq_ch", 32'(deq_ch_o), 32'd0);
    cyc(1'b1, 2'd2, 8'hA1, 1'b0, 4'b0, v, oc, r);
    check("t1_no_flow", 32'(v), 32'd0);
    check("t1_rdy", 32'(r), 32'd1);
    enq(2'd2, 8'hB2);
    enq(2'd2, 8'hC3);
    deq_one("t1_a", 2'd2);
    deq_one("t1_b", 2'd2);
    deq_one("t1_c", 2'd2);
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t1_drained", 32'(v), 32'd0);

    // Full channel back-pressure and PIPE bypass
    do_reset();
    for (int k = 0; k < DEPTH; k++) enq(2'd0, 8'h10 + 8'(k));
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t2_full_rdy0", 32'(r), 32'd0);
    cyc(1'b0, 2'd1, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t2_rdy1", 32'(r), 32'd1);
    cyc(1'b1, 2'd0, 8'h14, 1'b1, 4'b0, v, oc, r);
    check("t2_pipe_vld", 32'(v), 32'd1);
    check("t2_pipe_ch", 32'(oc), 32'd0);
    check("t2_pipe_rdy", 32'(r), 32'd1);
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t2_still_full", 32'(r), 32'd0);
`ifdef MULTI_CHAN_QUEUE_CNT_EN
    check("t2_cnt", 32'(cnt_o[CNT_W-1:0]), 32'd4);
`endif
    for (int k = 0; k < DEPTH; k++) deq_one("t2_drain", 2'd0);

    // Round-robin order
    do_reset();
    for (int c = 0; c < NUM_CH; c++) enq(2'(c), 8'h30 + 8'(c));
    for (int c = 0; c < NUM_CH; c++) deq_one("t3_rr", 2'(c));
    enq(2'd0, 8'h34);
    enq(2'd3, 8'h35);
    deq_one("t3_re0", 2'd0);
    deq_one("t3_re3", 2'd3);
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t3_drained", 32'(v), 32'd0);

    // Grant lock held under back-pressure
    do_reset();
    enq(2'd1, 8'h41);
    enq(2'd2, 8'h42);
    for (int k = 0; k < 5; k++) begin
      cyc(k < DEPTH, 2'd0, 8'h50 + 8'(k), 1'b0, 4'b0, v, oc, r);
      check("t4_lock_vld", 32'(v), 32'd1);
      check("t4_lock_ch", 32'(oc), 32'd1);
      check("t4_lock_bits", 32'(deq_bits_o), 32'h41);
    end
    deq_one("t4_ch1", 2'd1);
    deq_one("t4_ch2", 2'd2);
    for (int k = 0; k < DEPTH; k++) deq_one("t4_ch0", 2'd0);

    // Flush of the locked channel with a concurrent enqueue
    do_reset();
    enq(2'd1, 8'h61);
    enq(2'd1, 8'h62);
    enq(2'd2, 8'h63);
    cyc(1'b1, 2'd1, 8'h64, 1'b0, 4'b0010, v, oc, r);
    check("t5_pre_ch", 32'(oc), 32'd1);
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t5_move_vld", 32'(v), 32'd1);
    check("t5_move_ch", 32'(oc), 32'd2);
`ifdef MULTI_CHAN_QUEUE_CNT_EN
    check("t5_cnt1", 32'(cnt_o[2*CNT_W-1:CNT_W]), 32'd0);
`endif
    deq_one("t5_ch2", 2'd2);
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t5_ch1_empty", 32'(v), 32'd0);

    // Asynchronous reset mid-stream
    do_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 2; k++) enq(2'(c), 8'h70 + 8'(2 * c + k));
    cyc(1'b0, 2'd1, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t6_pre_vld", 32'(v), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rst_enq_rdy", 32'(enq_ready_o), 32'd1);
    check("t6_rst_deq_vld", 32'(deq_valid_o), 32'd0);
    check("t6_rst_deq_ch", 32'(deq_ch_o), 32'd0);
`ifdef MULTI_CHAN_QUEUE_CNT_EN
    check("t6_rst_cnt", 32'(cnt_o), 32'd0);
`endif
    sb_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(1'b0, 2'd0, 8'h00, 1'b0, 4'b0, v, oc, r);
    check("t6_post_vld", 32'(v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
